// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronizes the three coin sensors, debounces single coins into
// credit pulses, rejects coins that are overlapped or not wanted, and latches a jam when a sensor sticks.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOCKOUT_CYCLES  = 8,
    parameter int unsigned JAM_CYCLES      = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel_raw_i,
    input  logic       dime_raw_i,
    input  logic       quarter_raw_i,
    input  logic       enable_i,
    output logic       N_o,
    output logic       D_o,
    output logic       Q_o,
    output logic       reject_o,
    output logic       jam_o,
    output logic [7:0] coin_count_o
);

    // state        | meaning
    // IDLE         | waiting for a sensor to go high
    // DEBOUNCE     | one coin type captured, counting stable cycles
    // WAIT_RELEASE | credit/reject issued, waiting for all sensors low
    // LOCKOUT      | sensors ignored for LOCKOUT_CYCLES cycles
    // JAM          | sensor stuck; left only by reset
    typedef enum logic [2:0] {IDLE, DEBOUNCE, WAIT_RELEASE, LOCKOUT, JAM} state_t;

    localparam logic [15:0] DEB_TC  = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] LOCK_TC = 16'(LOCKOUT_CYCLES);
    localparam logic [15:0] JAM_TC  = 16'(JAM_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  sync1_q, sync2_q;   // {quarter, dime, nickel}
    logic [2:0]  coin_q, coin_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic [2:0]  credit_q, credit_d;
    logic        reject_q, reject_d;
    logic        jam_q;
    logic [7:0]  count_q, count_d;
    logic        one_hot, any_hi, accept;

    assign cnt_inc = cnt_q + 16'd1;
    assign any_hi  = |sync2_q;
    assign one_hot = (sync2_q == 3'b001) || (sync2_q == 3'b010) || (sync2_q == 3'b100);

    always_comb begin
        state_d  = state_q;
        coin_d   = coin_q;
        cnt_d    = cnt_q;
        credit_d = 3'b000;
        reject_d = 1'b0;
        count_d  = count_q;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_hot) begin
                    coin_d = sync2_q;
                    cnt_d  = 16'd1;
                    if (DEB_TC == 16'd1) accept = 1'b1;
                    else                 state_d = DEBOUNCE;
                end else if (any_hi) begin
                    reject_d = 1'b1;
                    cnt_d    = 16'd0;
                    state_d  = WAIT_RELEASE;
                end
            end
            DEBOUNCE: begin
                // a foreign line rising wins over the captured line dropping
                if ((sync2_q & ~coin_q) != 3'b000) begin
                    reject_d = 1'b1;
                    cnt_d    = 16'd0;
                    state_d  = WAIT_RELEASE;
                end else if (sync2_q == coin_q) begin
                    if (cnt_inc == DEB_TC) accept = 1'b1;
                    else                   cnt_d = cnt_inc;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_RELEASE: begin
                if (any_hi) begin
                    if (cnt_inc == JAM_TC) state_d = JAM;
                    else                   cnt_d = cnt_inc;
                end else begin
                    cnt_d   = 16'd0;
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (cnt_inc == LOCK_TC) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            JAM: ;
            default: state_d = IDLE;
        endcase

        // enable is only looked at here, in the acceptance cycle
        if (accept) begin
            state_d = WAIT_RELEASE;
            cnt_d   = 16'd0;
            if (enable_i) begin
                credit_d = coin_d;
                count_d  = count_q + 8'd1;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            coin_q   <= 3'b000;
            cnt_q    <= 16'd0;
            credit_q <= 3'b000;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= {quarter_raw_i, dime_raw_i, nickel_raw_i};
            sync2_q  <= sync1_q;
            coin_q   <= coin_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
            jam_q    <= (state_d == JAM);
            count_q  <= count_d;
        end
    end

    assign N_o          = credit_q[0];
    assign D_o          = credit_q[1];
    assign Q_o          = credit_q[2];
    assign reject_o     = reject_q;
    assign jam_o        = jam_q;
    assign coin_count_o = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: expected pulses (code + cycle) are queued when a coin is
// driven and popped by a monitor whenever the DUT raises N/D/Q/reject.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       reset;
    logic       nickel_raw, dime_raw, quarter_raw, enable;
    logic       n_p, d_p, q_p, rej_p, jam;
    logic [7:0] coin_count;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    localparam logic [3:0] C_N = 4'b1000;
    localparam logic [3:0] C_D = 4'b0100;
    localparam logic [3:0] C_Q = 4'b0010;
    localparam logic [3:0] C_R = 4'b0001;

    coin_acceptor dut (
        .clk          (clk),
        .reset        (reset),
        .nickel_raw_i (nickel_raw),
        .dime_raw_i   (dime_raw),
        .quarter_raw_i(quarter_raw),
        .enable_i     (enable),
        .N_o          (n_p),
        .D_o          (d_p),
        .Q_o          (q_p),
        .reject_o     (rej_p),
        .jam_o        (jam),
        .coin_count_o (coin_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [3:0] code, input int offset);
        int t;
        t = cyc + offset;
        sb.push_back({code, t[27:0]});
    endtask

    // pulse codes packed with the cycle count so timing and identity are compared together
    task automatic monitor();
        logic [3:0]  obs;
        logic [31:0] e;
        int          t;
        forever begin
            @(negedge clk);
            obs = {n_p, d_p, q_p, rej_p};
            if (obs != 4'b0000) begin
                t = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {obs, t[27:0]}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse", {obs, t[27:0]}, e);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        nickel_raw = 1'b0; dime_raw = 1'b0; quarter_raw = 1'b0;
        enable = 1'b1;
        fork
            monitor();
        join_none
        wait_cyc(3);
        chk("rst_pulses", {28'd0, n_p, d_p, q_p, rej_p}, 32'd0);
        chk("rst_jam", 32'(jam), 32'd0);
        chk("rst_count", 32'(coin_count), 32'd0);
        reset = 1'b1;
        wait_cyc(2);

        // nickel held 10 cycles: N five edges after the first sampling edge
        nickel_raw = 1'b1; expect_pulse(C_N, 6);
        wait_cyc(10); nickel_raw = 1'b0;
        wait_cyc(20);
        chk("count_nickel", 32'(coin_count), 32'd1);
        chk("sb_empty_nickel", 32'(sb.size()), 32'd0);

        // short dime: bounce dropped silently
        dime_raw = 1'b1;
        wait_cyc(2); dime_raw = 1'b0;
        wait_cyc(10);
        chk("count_short_dime", 32'(coin_count), 32'd1);

        // two coins together: one reject, then a dime proves IDLE after lockout
        nickel_raw = 1'b1; quarter_raw = 1'b1; expect_pulse(C_R, 3);
        wait_cyc(5); nickel_raw = 1'b0; quarter_raw = 1'b0;
        wait_cyc(20);
        chk("sb_empty_double", 32'(sb.size()), 32'd0);
        dime_raw = 1'b1; expect_pulse(C_D, 6);
        wait_cyc(8); dime_raw = 1'b0;
        wait_cyc(20);
        chk("count_after_double", 32'(coin_count), 32'd2);

        // enable low at acceptance: reject, no credit
        enable = 1'b0;
        quarter_raw = 1'b1; expect_pulse(C_R, 6);
        wait_cyc(10); quarter_raw = 1'b0; enable = 1'b1;
        wait_cyc(20);
        chk("count_disabled_q", 32'(coin_count), 32'd2);

        // enable low while debouncing but high in the acceptance cycle: credited
        enable = 1'b0;
        quarter_raw = 1'b1; expect_pulse(C_Q, 6);
        wait_cyc(5); enable = 1'b1;
        wait_cyc(3); enable = 1'b0; quarter_raw = 1'b0;
        wait_cyc(20); enable = 1'b1;
        chk("count_late_enable_q", 32'(coin_count), 32'd3);
        chk("sb_empty_enable", 32'(sb.size()), 32'd0);

        // stuck dime: one D, jam after 64 cycles in WAIT_RELEASE, sticky
        dime_raw = 1'b1; expect_pulse(C_D, 6);
        wait_cyc(69);
        chk("jam_before_limit", 32'(jam), 32'd0);
        wait_cyc(1);
        chk("jam_at_limit", 32'(jam), 32'd1);
        wait_cyc(30); dime_raw = 1'b0;
        wait_cyc(20);
        chk("jam_sticky", 32'(jam), 32'd1);
        nickel_raw = 1'b1;
        wait_cyc(10); nickel_raw = 1'b0;
        wait_cyc(5);
        chk("count_in_jam", 32'(coin_count), 32'd4);
        chk("sb_empty_jam", 32'(sb.size()), 32'd0);
        reset = 1'b0;
        wait_cyc(1);
        chk("jam_cleared", 32'(jam), 32'd0);
        chk("count_cleared", 32'(coin_count), 32'd0);
        reset = 1'b1;
        wait_cyc(2);

        // reset mid-debounce aborts; held sensor is re-seen as a new coin
        nickel_raw = 1'b1;
        wait_cyc(4); reset = 1'b0;
        wait_cyc(1); reset = 1'b1; expect_pulse(C_N, 6);
        wait_cyc(10); nickel_raw = 1'b0;
        wait_cyc(20);
        chk("count_after_abort", 32'(coin_count), 32'd1);
        chk("sb_empty_abort", 32'(sb.size()), 32'd0);

        // fill the counter to 255, then wrap
        for (int i = 0; i < 254; i++) begin
            nickel_raw = 1'b1; expect_pulse(C_N, 6);
            wait_cyc(6); nickel_raw = 1'b0;
            wait_cyc(14);
        end
        chk("count_255", 32'(coin_count), 32'd255);
        nickel_raw = 1'b1; expect_pulse(C_N, 6);
        wait_cyc(6); nickel_raw = 1'b0;
        wait_cyc(14);
        chk("count_wrap", 32'(coin_count), 32'd0);
        chk("jam_after_wrap", 32'(jam), 32'd0);

        // dime during lockout ignored; the same coin after lockout is credited
        nickel_raw = 1'b1; expect_pulse(C_N, 6);
        wait_cyc(6); nickel_raw = 1'b0;
        wait_cyc(4); dime_raw = 1'b1;
        wait_cyc(3); dime_raw = 1'b0;
        wait_cyc(7);
        dime_raw = 1'b1; expect_pulse(C_D, 6);
        wait_cyc(8); dime_raw = 1'b0;
        wait_cyc(20);
        chk("count_lockout", 32'(coin_count), 32'd2);
        chk("sb_empty_final", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
